// File: rtl/ram_arbiter.sv
// Two-master arbiter/sequencer for the single-port data RAM (m0 = MEM stage, m1 = fetch).
// Optional WAIT-state timeout abort is enabled by defining ARB_TIMEOUT_EN.
module ram_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int M1_MAX_WAIT = 4,
   parameter int TIMEOUT     = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_done,
   output logic              m0_stall,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_done,
   output logic              m1_stall,
   output logic              m1_err,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ack,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] MAX_WAIT = 4'(M1_MAX_WAIT);

   state_t            r_state;
   logic              r_gnt;
   logic              r_lat_we;
   logic              r_err;
   logic              r_done;
   logic              r_ce;
   logic              r_we;
   logic              r_busy;
   logic [3:0]        r_wait_cnt;
`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   logic [7:0]        r_tmo_cnt;
`endif

   logic              w_any_req;
   logic              w_gnt_m1;
   logic [DATA_W-1:0] w_rdata;

   // m1 wins outright when m0 is idle, or when m0 has starved it long enough
   assign w_any_req = m0_req | m1_req;
   assign w_gnt_m1  = m1_req & (~m0_req | (r_wait_cnt >= MAX_WAIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_gnt      <= 1'b0;
         r_lat_we   <= 1'b0;
         r_err      <= 1'b0;
         r_done     <= 1'b0;
         r_ce       <= 1'b0;
         r_we       <= 1'b0;
         r_busy     <= 1'b0;
         r_wait_cnt <= '0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
`ifdef ARB_TIMEOUT_EN
         r_tmo_cnt  <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_gnt     <= w_gnt_m1;
                  r_lat_we  <= w_gnt_m1 ? m1_we    : m0_we;
                  r_we      <= w_gnt_m1 ? m1_we    : m0_we;
                  ram_addr  <= w_gnt_m1 ? m1_addr  : m0_addr;
                  ram_wdata <= w_gnt_m1 ? m1_wdata : m0_wdata;
                  r_err     <= 1'b0;
                  r_ce      <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= S_ISSUE;
               end
               // m1 still waiting here implies m0 took the grant this cycle
               if (w_gnt_m1 || !m1_req)
                  r_wait_cnt <= '0;
               else if (r_wait_cnt != 4'hF)
                  r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            S_ISSUE: begin
               r_we <= 1'b0;
               if (r_lat_we) begin
                  r_state   <= S_WAIT;
`ifdef ARB_TIMEOUT_EN
                  r_tmo_cnt <= '0;
`endif
               end else begin
                  r_state <= S_RESP;
                  r_ce    <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_WAIT: begin
               if (ram_ack) begin
                  r_state <= S_RESP;
                  r_ce    <= 1'b0;
                  r_done  <= 1'b1;
               end
`ifdef ARB_TIMEOUT_EN
               else if (r_tmo_cnt == TMO_LAST) begin
                  r_state   <= S_RESP;
                  r_ce      <= 1'b0;
                  r_done    <= 1'b1;
                  r_err     <= 1'b1;
                  r_tmo_cnt <= r_tmo_cnt + 8'd1;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 8'd1;
               end
`endif
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_err   <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // RAM registers read data, so it is valid in RESP right after the ISSUE cycle
   assign w_rdata  = (r_done & ~r_lat_we & ~r_err) ? ram_rdata : '0;

   assign m0_done  = r_done & ~r_gnt;
   assign m1_done  = r_done &  r_gnt;
   assign m0_rdata = m0_done ? w_rdata : '0;
   assign m1_rdata = m1_done ? w_rdata : '0;
   assign m0_stall = m0_req & ~m0_done;
   assign m1_stall = m1_req & ~m1_done;
`ifdef ARB_TIMEOUT_EN
   assign m0_err   = m0_done & r_err;
   assign m1_err   = m1_done & r_err;
`else
   assign m0_err   = 1'b0;
   assign m1_err   = 1'b0;
`endif

   assign ram_ce   = r_ce;
   assign ram_we   = r_we;
   assign busy     = r_busy;

endmodule
